can_rx_mm_writer: RTL and testbench
===================================

CAN_RX_MM_WRITER -- requirements
Module: can_rx_mm_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 11'h000, the word address of the ring buffer in the 2048x16 on-chip RAM.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving a ring of 2^DEPTH_LOG2 frame records of 8 words each; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port frame_valid, input, 1 bit: the CAN receiver presents a frame.
REQ-006 SHALL have port frame_ready, output, 1 bit: the block accepts the frame.
REQ-007 SHALL have port frame_id, input, 29 bits: identifier (standard IDs right-aligned).
REQ-008 SHALL have ports frame_ide and frame_rtr, input, 1 bit each: extended-ID flag and remote-frame flag.
REQ-009 SHALL have port frame_dlc, input, 4 bits: data length code.
REQ-010 SHALL have port frame_data, input, 64 bits: data byte n on bits [8n+7:8n].
REQ-011 SHALL have Avalon-MM master outputs: avm_address (11 bits), avm_chipselect (1), avm_write (1), avm_writedata (16), avm_byteenable (2).
REQ-012 SHALL have port avm_waitrequest, input, 1 bit; tie it to 0 when the block drives the RAM directly.
REQ-013 SHALL have port rd_ptr, input, DEPTH_LOG2+1 bits: consumer tail index, including the wrap bit.
REQ-014 SHALL have port wr_ptr, output, DEPTH_LOG2+1 bits: producer head index, including the wrap bit.
REQ-015 SHALL have port drop_count, output, 16 bits: frames discarded because the ring was full.
REQ-016 SHALL have port irq, output, 1 bit: high while the ring holds unread frames.

Function
REQ-017 SHALL implement the FSM states IDLE, WRITE and COMMIT.
REQ-018 SHALL drive frame_ready high only in IDLE; a transfer occurs when frame_valid and frame_ready are both high.
REQ-019 SHALL treat the ring as full when (wr_ptr - rd_ptr) mod 2^(DEPTH_LOG2+1) equals 2^DEPTH_LOG2.
REQ-020 SHALL, on a transfer while full: discard the frame, increment drop_count (saturating at 16'hFFFF), stay in IDLE and issue no bus write.
REQ-021 SHALL, on a transfer while not full: latch all frame fields, set word_idx=0 and go to WRITE.
REQ-022 SHALL, in WRITE, assert avm_chipselect=avm_write=1 and avm_byteenable=2'b11.
REQ-023 SHALL, in WRITE, drive avm_address = BASE_ADDR + {wr_ptr[DEPTH_LOG2-1:0], word_idx}, truncated to 11 bits.
REQ-024 SHALL hold address and data stable while avm_waitrequest is high, and advance word_idx only on a cycle where avm_waitrequest is low.
REQ-025 SHALL use the record layout w0={ide,rtr,1'b0,id[28:16]}, w1=id[15:0], w2={12'h000,dlc}, w3..w6={byte(2k+1),byte(2k)} for k=0..3, and w7=seq.
REQ-026 SHALL write all 8 data bytes regardless of dlc.
REQ-027 SHALL keep seq as a 16-bit committed-frame counter, wrapping; w7 carries the value held before the increment.
REQ-028 SHALL, after w7 completes, enter COMMIT for one cycle; in COMMIT wr_ptr and seq each increment by 1 (modulo width) and the FSM returns to IDLE.
REQ-029 SHALL complete a frame transferred in cycle T, with zero waitrequest, as: words on T+1..T+8, wr_ptr updated visible T+10, frame_ready high again T+10.
REQ-030 SHALL keep avm_write and avm_chipselect low outside WRITE.
REQ-031 SHALL drive irq = (wr_ptr != rd_ptr), registered.
REQ-032 SHALL make a rd_ptr change take effect on the full test in the next cycle; the full test is sampled only in IDLE.

Reset
REQ-033 SHALL, when reset_n is low at a clock edge, set state=IDLE, wr_ptr=0, seq=0, drop_count=0, irq=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
REQ-034 SHALL drive frame_ready=0 while reset_n is low.
REQ-035 SHALL, on reset mid-WRITE, abandon the frame; partially written words remain in RAM but are never committed.

Structure
REQ-036 SHALL place in the shared package can_mm_pkg: the state enum, RECORD_WORDS=8, the word offsets W_IDHI..W_SEQ, and the w0 flag bit positions.
REQ-037 SHALL place word formatting in one combinational sub-module, can_frame_word_mux (latched frame and word_idx in, 16-bit word out).

Verification
REQ-038 SHALL cover: one frame id=29'h1ABCDE12, ide=1, dlc=8, data=64'h0807060504030201, BASE 0 -> writes at 0..7 of 16'h9ABC, 16'hDE12, 16'h0008, 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0000; wr_ptr=1; irq=1.
REQ-039 SHALL cover: DEPTH_LOG2=1, rd_ptr=0, three frames -> third frame dropped, drop_count=1, wr_ptr=2'b10, no write on the third frame.
REQ-040 SHALL cover: avm_waitrequest high for 3 cycles on w2 -> w2 held stable, frame finishes 3 cycles later, all words correct.
REQ-041 SHALL cover: wrap with DEPTH_LOG2=2, BASE 11'h100 -> frame 4 writes at 11'h100..11'h107, wr_ptr=3'b101.
REQ-042 SHALL cover: reset_n low on word 4 -> wr_ptr=0, avm_write=0 the next cycle; the next frame writes from address BASE with seq=0.

Source files
------------

// File: rtl/can_rx_mm_writer_pkg.sv
// can_mm_pkg: shared types and record layout constants for the CAN receive ring writer
package can_mm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int RECORD_WORDS = 8;
    localparam int WORD_IDX_W   = $clog2(RECORD_WORDS);

    localparam logic [WORD_IDX_W-1:0] W_IDHI = 3'd0;
    localparam logic [WORD_IDX_W-1:0] W_IDLO = 3'd1;
    localparam logic [WORD_IDX_W-1:0] W_DLC  = 3'd2;
    localparam logic [WORD_IDX_W-1:0] W_D0   = 3'd3;
    localparam logic [WORD_IDX_W-1:0] W_D1   = 3'd4;
    localparam logic [WORD_IDX_W-1:0] W_D2   = 3'd5;
    localparam logic [WORD_IDX_W-1:0] W_D3   = 3'd6;
    localparam logic [WORD_IDX_W-1:0] W_SEQ  = 3'd7;

    localparam int IDE_BIT = 15;
    localparam int RTR_BIT = 14;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } frame_t;

endpackage

// File: rtl/can_rx_mm_writer_if.sv
// can_rx_mm_writer_if: frame handshake from the CAN receiver plus the Avalon-MM write port
interface can_rx_mm_writer_if;

    logic        frame_valid;
    logic        frame_ready;
    logic [28:0] frame_id;
    logic        frame_ide;
    logic        frame_rtr;
    logic [3:0]  frame_dlc;
    logic [63:0] frame_data;

    logic [10:0] avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest;

    modport master (
        input  frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data,
        input  avm_waitrequest,
        output frame_ready,
        output avm_address, avm_chipselect, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data,
        output avm_waitrequest,
        input  frame_ready,
        input  avm_address, avm_chipselect, avm_write, avm_writedata, avm_byteenable
    );

endinterface

// File: rtl/can_rx_mm_writer_word_mux.sv
// can_frame_word_mux: selects one 16-bit word of a frame record by word index
module can_frame_word_mux
    import can_mm_pkg::*;
(
    input  frame_t                frame,
    input  logic [15:0]           seq,
    input  logic [WORD_IDX_W-1:0] word_idx,
    output logic [15:0]           word
);

    // record layout: header, id low, dlc, four data byte pairs, sequence number
    always_comb begin
        word = seq;
        case (word_idx)
            W_IDHI: begin
                word = {3'b000, frame.id[28:16]};
                word[IDE_BIT] = frame.ide;
                word[RTR_BIT] = frame.rtr;
            end
            W_IDLO:  word = frame.id[15:0];
            W_DLC:   word = {12'h000, frame.dlc};
            W_D0:    word = frame.data[15:0];
            W_D1:    word = frame.data[31:16];
            W_D2:    word = frame.data[47:32];
            W_D3:    word = frame.data[63:48];
            default: word = seq;
        endcase
    end

endmodule

// File: rtl/can_rx_mm_writer.sv
// can_rx_mm_writer: stores received CAN frames as 8-word records in a RAM ring buffer
module can_rx_mm_writer
    import can_mm_pkg::*;
#(
    parameter logic [10:0] BASE_ADDR  = 11'h000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    can_rx_mm_writer_if.master        bus,
    input  logic [DEPTH_LOG2:0]       rd_ptr,
    output logic [DEPTH_LOG2:0]       wr_ptr,
    output logic [15:0]               drop_count,
    output logic                      irq
);

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                  state;
    state_t                  state_next;
    frame_t                  frame_q;
    logic [WORD_IDX_W-1:0]   word_idx;
    logic [15:0]             seq;
    logic [15:0]             word;
    logic [DEPTH_LOG2:0]     rd_ptr_q;
    logic [DEPTH_LOG2:0]     used;
    logic                    accept;
    logic                    full;
    logic                    word_done;

    assign accept    = state == IDLE && bus.frame_valid;
    assign used      = wr_ptr - rd_ptr_q;
    assign full      = used == FULL_LEVEL;
    assign word_done = state == WRITE && !bus.avm_waitrequest;

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // next state: accept into WRITE, leave WRITE after the last word lands, COMMIT lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept && !full ? WRITE : IDLE;
            WRITE:   state_next = word_done && word_idx == W_SEQ ? COMMIT : WRITE;
            default: state_next = IDLE;
        endcase
    end

    // outputs: the bus is driven only while writing, everything else parks at zero
    always_comb begin
        bus.frame_ready    = reset_n && state == IDLE;
        bus.avm_chipselect = state == WRITE;
        bus.avm_write      = state == WRITE;
        bus.avm_byteenable = state == WRITE ? 2'b11 : 2'b00;
        bus.avm_address    = state == WRITE ? BASE_ADDR + 11'({wr_ptr[DEPTH_LOG2-1:0], word_idx}) : 11'h000;
        bus.avm_writedata  = state == WRITE ? word : 16'h0000;
    end

    // consumer pointer is registered so a change reaches the full test one cycle later
    always_ff @(posedge clk) rd_ptr_q <= rd_ptr;

    // datapath: frame capture, word sequencing, ring head, sequence and drop counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            seq        <= '0;
            drop_count <= '0;
            irq        <= 1'b0;
            word_idx   <= '0;
        end else begin
            irq <= wr_ptr != rd_ptr;
            if (accept && full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (accept && !full) begin
                frame_q.id   <= bus.frame_id;
                frame_q.ide  <= bus.frame_ide;
                frame_q.rtr  <= bus.frame_rtr;
                frame_q.dlc  <= bus.frame_dlc;
                frame_q.data <= bus.frame_data;
                word_idx     <= '0;
            end
            if (word_done) word_idx <= word_idx + 1'b1;
            if (state == COMMIT) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 16'd1;
            end
        end
    end

    can_frame_word_mux u_word_mux (
        .frame    (frame_q),
        .seq      (seq),
        .word_idx (word_idx),
        .word     (word)
    );

endmodule

// File: tb/tb_can_rx_mm_writer.sv
// tb_can_rx_mm_writer: scoreboard bench for the CAN receive ring writer
module tb_can_rx_mm_writer;

    localparam int          D    = 2;
    localparam int          RING = 1 << D;
    localparam logic [10:0] BASE = 11'h100;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [D:0]   rd_ptr  = '0;
    logic [D:0]   wr_ptr;
    logic [15:0]  drop_count;
    logic         irq;

    can_rx_mm_writer_if bus ();

    can_rx_mm_writer #(.BASE_ADDR(BASE), .DEPTH_LOG2(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .rd_ptr     (rd_ptr),
        .wr_ptr     (wr_ptr),
        .drop_count (drop_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, t_xfer = 0;
    int m_wr = 0, m_rd = 0, m_seq = 0, m_drops = 0;
    logic [26:0] exp_q[$];
    logic rand_wait = 1'b0, force_wait = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // waitrequest changes just after the edge so both DUT and monitor see it stable
    always @(posedge clk) begin
        #1;
        bus.avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : force_wait;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // reference model: occupancy is the plain difference of frames produced and consumed
    task automatic model_frame(input logic [28:0] id, input logic ide, input logic rtr,
                               input logic [3:0] dlc, input logic [63:0] data);
        logic [15:0] w [8];
        int slot;
        if (m_wr - m_rd == RING) begin
            if (m_drops < 65535) m_drops++;
        end else begin
            slot = m_wr % RING;
            w[0] = {ide, rtr, 1'b0, id[28:16]};
            w[1] = id[15:0];
            w[2] = {12'h000, dlc};
            for (int k = 0; k < 4; k++) w[3+k] = data[16*k +: 16];
            w[7] = 16'(m_seq);
            for (int k = 0; k < 8; k++) exp_q.push_back({BASE + 11'(slot * 8 + k), w[k]});
            m_wr++;
            m_seq = (m_seq + 1) % 65536;
        end
    endtask

    task automatic send_frame(input logic [28:0] id, input logic ide, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data);
        int n = 0;
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.frame_id    = id;
        bus.frame_ide   = ide;
        bus.frame_rtr   = rtr;
        bus.frame_dlc   = dlc;
        bus.frame_data  = data;
        while (!bus.frame_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", bus.frame_ready, 1);
        t_xfer = cyc;
        model_frame(id, ide, rtr, dlc, data);
        @(posedge clk);
        #1 bus.frame_valid = 1'b0;
    endtask

    task automatic send_rand();
        send_frame(29'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom});
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat = cyc - t_xfer;
        end while (!bus.frame_ready && lat < 400);
        if (!bus.frame_ready) chk("idle_timeout", bus.frame_ready, 1);
    endtask

    task automatic check_ptrs();
        chk("wr_ptr", 32'(wr_ptr), 32'(m_wr[D:0]));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    task automatic set_rd(input int v);
        @(negedge clk);
        m_rd   = v;
        rd_ptr = m_rd[D:0];
    endtask

    // monitor: every cycle with the bus active is compared against the head of the queue
    always @(negedge clk) begin
        if (reset_n && (bus.avm_write || bus.avm_chipselect)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr 'h%0h data 'h%0h, expected no write",
                         bus.avm_address, bus.avm_writedata);
            end else begin
                chk("wr_strobes", {28'd0, bus.avm_chipselect, bus.avm_write, bus.avm_byteenable}, 32'hF);
                chk("wr_addr", 32'(bus.avm_address), 32'(exp_q[0][26:16]));
                chk("wr_data", 32'(bus.avm_writedata), 32'(exp_q[0][15:0]));
                if (!bus.avm_waitrequest) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.frame_valid = 1'b0;
        bus.frame_id    = '0;
        bus.frame_ide   = 1'b0;
        bus.frame_rtr   = 1'b0;
        bus.frame_dlc   = '0;
        bus.frame_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_frame_ready", bus.frame_ready, 0);
        chk("rst_wr_ptr", 32'(wr_ptr), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_irq", irq, 0);
        chk("rst_write", {bus.avm_write, bus.avm_chipselect, bus.avm_byteenable}, 0);
        chk("rst_address", 32'(bus.avm_address), 0);
        chk("rst_writedata", 32'(bus.avm_writedata), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_frame_ready", bus.frame_ready, 1);

        send_frame(29'h1ABCDE12, 1'b1, 1'b0, 4'd8, 64'h0807060504030201);
        wait_idle(lat);
        chk("latency", lat, 10);
        check_ptrs();
        @(negedge clk);
        chk("irq_set", irq, 1);

        repeat (RING - 1) begin
            send_rand();
            wait_idle(lat);
            check_ptrs();
        end
        repeat (2) begin
            send_rand();
            wait_idle(lat);
            check_ptrs();
        end
        chk("drops_when_full", 32'(drop_count), 2);
        chk("full_wr_ptr", 32'(wr_ptr), 32'b100);

        set_rd(m_wr);
        repeat (2) @(negedge clk);
        chk("irq_clear", irq, 0);
        send_rand();
        wait_idle(lat);
        check_ptrs();
        chk("wrap_wr_ptr", 32'(wr_ptr), 32'b101);

        send_rand();
        @(negedge clk);
        @(negedge clk);
        force_wait = 1'b1;
        repeat (3) @(negedge clk);
        force_wait = 1'b0;
        wait_idle(lat);
        chk("stall_latency", lat, 13);
        check_ptrs();

        rand_wait = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) set_rd(m_rd + int'($urandom_range(0, m_wr - m_rd)));
            send_rand();
            wait_idle(lat);
            check_ptrs();
        end
        rand_wait = 1'b0;
        set_rd(m_wr);
        repeat (3) @(negedge clk);

        send_rand();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd_ptr  = '0;
        m_rd    = 0;
        m_wr    = 0;
        m_seq   = 0;
        m_drops = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_wr_ptr", 32'(wr_ptr), 0);
        chk("midrst_write", bus.avm_write, 0);
        chk("midrst_drops", 32'(drop_count), 0);

        send_frame(29'h00000123, 1'b0, 1'b1, 4'd2, 64'hA5A5_5A5A_1234_CDEF);
        wait_idle(lat);
        chk("post_rst_latency", lat, 10);
        check_ptrs();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
